chan_router: RTL and testbench

CHAN_ROUTER -- requirements
Module: chan_router

---
 rtl/chan_router_pkg.sv | 20 ++
 rtl/chan_fifo.sv | 76 +++++++
 rtl/chan_router.sv | 95 +++++++++
 tb/tb_chan_router.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_router_pkg.sv
//------------------------------------------------------------------------------
// chan_router_pkg : shared defaults and drop-counter constants for chan_router
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package chan_router_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ID_W     = 2;
    localparam int DEF_NUM_CH   = 3;
    localparam int DEF_DEPTH    = 4;

    localparam int DROP_CNT_W   = 8;
    localparam int DROP_CNT_MAX = 255;

endpackage : chan_router_pkg

`default_nettype wire

// File: rtl/chan_fifo.sv
//------------------------------------------------------------------------------
// chan_fifo : registered single-clock FIFO with occupancy counter, no fall-through
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module chan_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_full,
    input  logic              i_pop,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    // Full/empty come only from the registered count, so a pop frees space
    // for a push starting the following cycle.
    assign w_full    = (r_count == c_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~w_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    // Masked when empty so the head reads zero during and after reset.
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule : chan_fifo

`default_nettype wire

// File: rtl/chan_router.sv
//------------------------------------------------------------------------------
// chan_router : routes ingress beats into per-channel FIFOs; drops invalid IDs
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module chan_router
    import chan_router_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ID_W   = DEF_ID_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [ID_W-1:0]          in_ch,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic                     drop_pulse,
    output logic [DROP_CNT_W-1:0]    drop_cnt
);

    localparam logic [ID_W:0]         c_NUM_CH   = (ID_W+1)'(NUM_CH);
    localparam logic [DROP_CNT_W-1:0] c_DROP_MAX = DROP_CNT_W'(DROP_CNT_MAX);

    logic              w_id_valid;
    logic              w_sel_full;
    logic              w_drop_acc;
    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_pop;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;

    logic                  r_drop_pulse;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    assign w_id_valid = ({1'b0, in_ch} < c_NUM_CH);

    always_comb begin
        w_sel_full = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (in_ch == ID_W'(k)) begin
                w_sel_full = w_full[k];
            end
        end
    end

    // Invalid IDs are always accepted so they can be discarded.
    assign in_ready   = w_id_valid ? ~w_sel_full : 1'b1;
    assign w_drop_acc = in_valid & ~w_id_valid;

    for (genvar g_k = 0; g_k < NUM_CH; g_k++) begin : g_ch
        assign w_push[g_k]    = in_valid & w_id_valid & (in_ch == ID_W'(g_k));
        assign w_pop[g_k]     = out_ready[g_k] & ~w_empty[g_k];
        assign out_valid[g_k] = ~w_empty[g_k];

        chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[g_k]),
            .i_data  (in_data),
            .o_full  (w_full[g_k]),
            .i_pop   (w_pop[g_k]),
            .o_empty (w_empty[g_k]),
            .o_data  (out_data[g_k*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_pulse <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_drop_pulse <= w_drop_acc;
            if (w_drop_acc && (r_drop_cnt != c_DROP_MAX)) begin
                r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

    assign drop_pulse = r_drop_pulse;
    assign drop_cnt   = r_drop_cnt;

endmodule : chan_router

`default_nettype wire

// File: tb/tb_chan_router.sv
//------------------------------------------------------------------------------
// tb_chan_router : directed stimulus with per-channel scoreboard queues
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_chan_router;

    localparam int DW = 8;
    localparam int NC = 3;

    typedef struct {
        logic [DW-1:0] d;
        int            cyc;
        bit            strict;
    } item_t;

    logic            clk;
    logic            rst_n;
    logic [DW-1:0]   in_data;
    logic [1:0]      in_ch;
    logic            in_valid;
    logic            in_ready;
    logic [NC*DW-1:0] out_data;
    logic [NC-1:0]   out_valid;
    logic [NC-1:0]   out_ready;
    logic            drop_pulse;
    logic [7:0]      drop_cnt;

    int    checks;
    int    errors;
    int    cyc;
    int    exp_drop;
    int    first_pop1;
    item_t sb [NC][$];

    item_t         m_it;
    logic [DW-1:0] m_od;
    bit            hold_v [NC];
    logic [DW-1:0] hold_d [NC];

    chan_router dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_ch      (in_ch),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called in the drive phase (1 time unit after a rising edge); returns there.
    task automatic send(input logic [DW-1:0] d, input logic [1:0] ch,
                        input bit strict, output int acc_cyc);
        item_t it;
        bit    done;
        int    n;
        done    = 1'b0;
        n       = 0;
        acc_cyc = -1;
        in_data  = d;
        in_ch    = ch;
        in_valid = 1'b1;
        while (!done && n < 64) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done    = 1'b1;
                acc_cyc = cyc;
                if (ch < 2'(NC)) begin
                    it.d = d;
                    it.cyc = cyc;
                    it.strict = strict;
                    sb[ch].push_back(it);
                    chk("drop_pulse_after_valid", int'(drop_pulse), 0);
                end else begin
                    exp_drop = (exp_drop == 255) ? 255 : exp_drop + 1;
                    chk("drop_pulse_after_invalid", int'(drop_pulse), 1);
                    chk("drop_cnt", int'(drop_cnt), exp_drop);
                end
            end else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: data %0d ch %0d never accepted", d, ch);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_remaining", sb[0].size() + sb[1].size() + sb[2].size(), 0);
    endtask

    // Monitor: decides at the falling edge which heads transfer on the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NC; k++) hold_v[k] = 1'b0;
        end else begin
            for (int k = 0; k < NC; k++) begin
                m_od = out_data[k*DW +: DW];
                if (hold_v[k] && out_valid[k]) begin
                    checks++;
                    if (m_od !== hold_d[k]) begin
                        errors++;
                        $display("FAIL stable_ch%0d: got %0d expected %0d", k, m_od, hold_d[k]);
                    end
                end
                if (out_valid[k] && out_ready[k]) begin
                    checks++;
                    if (sb[k].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_ch%0d: got %0d expected nothing", k, m_od);
                    end else begin
                        m_it = sb[k].pop_front();
                        if (m_od !== m_it.d) begin
                            errors++;
                            $display("FAIL data_ch%0d: got %0d expected %0d", k, m_od, m_it.d);
                        end
                        if (m_it.strict) begin
                            checks++;
                            if (cyc != m_it.cyc) begin
                                errors++;
                                $display("FAIL latency_ch%0d: got cycle %0d expected %0d", k, cyc, m_it.cyc);
                            end
                        end
                    end
                    if (k == 1 && first_pop1 < 0) first_pop1 = cyc + 1;
                end
                hold_v[k] = out_valid[k] && !out_ready[k];
                hold_d[k] = m_od;
            end
        end
    end

    initial begin
        int acc;
        checks     = 0;
        errors     = 0;
        exp_drop   = 0;
        first_pop1 = -1;
        rst_n      = 1'b0;
        in_data    = '0;
        in_ch      = '0;
        in_valid   = 1'b0;
        out_ready  = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_drop_pulse", int'(drop_pulse), 0);
        chk("reset_drop_cnt", int'(drop_cnt), 0);
        rst_n = 1'b1;

        // Basic routing, one-cycle latency, one invalid ID.
        send(8'd10, 2'd0, 1'b1, acc);
        send(8'd20, 2'd1, 1'b1, acc);
        send(8'd30, 2'd2, 1'b1, acc);
        send(8'd40, 2'd3, 1'b0, acc);
        @(posedge clk);
        #1;
        chk("drop_pulse_single", int'(drop_pulse), 0);
        chk("drop_cnt_after_one", int'(drop_cnt), 1);
        drain();

        // Fill stalled ch1; fifth beat must be refused.
        out_ready[1] = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(i), 2'd1, 1'b0, acc);
        in_data  = 8'd5;
        in_ch    = 2'd1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("ch1_full_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;

        // Other channels unaffected by full ch1.
        send(8'd51, 2'd0, 1'b1, acc);
        send(8'd52, 2'd2, 1'b1, acc);
        send(8'd53, 2'd0, 1'b1, acc);
        in_ch    = 2'd1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("ch1_still_full", int'(in_ready), 0);
        @(posedge clk);
        #1;

        out_ready[1] = 1'b1;
        first_pop1   = -1;
        send(8'd5, 2'd1, 1'b0, acc);
        chk("ch1_accept_after_pop", acc, first_pop1 + 1);
        drain();

        // Ch0 holds two entries, then simultaneous push/pop for ten cycles.
        out_ready[0] = 1'b0;
        send(8'd100, 2'd0, 1'b0, acc);
        send(8'd101, 2'd0, 1'b0, acc);
        out_ready[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(8'(110 + i), 2'd0, 1'b0, acc);
        end
        out_ready[0] = 1'b0;
        send(8'd120, 2'd0, 1'b0, acc);
        send(8'd121, 2'd0, 1'b0, acc);
        in_ch    = 2'd0;
        in_valid = 1'b1;
        @(negedge clk);
        chk("ch0_occupancy_was_two", int'(in_ready), 0);
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        out_ready[0] = 1'b1;
        drain();

        // Saturate the drop counter.
        for (int i = 0; i < 300; i++) send(8'(i), 2'd3, 1'b0, acc);
        chk("drop_cnt_saturated", int'(drop_cnt), 255);

        // Reset mid-stream with ch2 holding three entries.
        out_ready[2] = 1'b0;
        send(8'd61, 2'd2, 1'b0, acc);
        send(8'd62, 2'd2, 1'b0, acc);
        send(8'd63, 2'd2, 1'b0, acc);
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", int'(out_valid), 0);
        chk("midreset_out_data", int'(out_data), 0);
        chk("midreset_drop_cnt", int'(drop_cnt), 0);
        for (int k = 0; k < NC; k++) sb[k].delete();
        exp_drop = 0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 3'b111;
        @(negedge clk);
        chk("post_reset_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        send(8'd77, 2'd2, 1'b1, acc);
        send(8'd88, 2'd0, 1'b1, acc);
        send(8'd99, 2'd3, 1'b0, acc);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_chan_router

`default_nettype wire
